// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite compositor.
//   - default parameter values for the top level
//   - scan FSM state encoding
//   - descriptor record laid out for the default field widths
package sprite_pkg;

    localparam int unsigned DefNumSprites = 4;
    localparam int unsigned DefScreenH    = 64;
    localparam int unsigned DefXgW        = 5;
    localparam int unsigned DefRowW       = 6;
    localparam int unsigned DefDimW       = 8;
    localparam int unsigned DefTexAw      = 16;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain,
        StResp
    } state_e;

    // One sprite descriptor at the default widths.
    typedef struct packed {
        logic                en;
        logic [DefXgW-1:0]   xg;
        logic [DefRowW-1:0]  y;
        logic [DefDimW-1:0]  wg;
        logic [DefDimW-1:0]  h;
        logic [DefTexAw-1:0] base;
    } desc_t;

endpackage

// File: rtl/sprite_hit_addr.sv
// sprite_hit_addr: combinational hit test and texture address for one sprite.
// Ports:
//   en_i, sx_i, sy_i, wg_i, h_i, base_i : descriptor of the sprite under test
//   xg_i, row_i                         : requested column group and row (0 = top)
//   hit_o                               : request position lies inside the sprite
//   addr_o                              : texture byte address for that position
module sprite_hit_addr
    import sprite_pkg::*;
#(
    parameter int unsigned SCREEN_H = DefScreenH,
    parameter int unsigned XG_W     = DefXgW,
    parameter int unsigned ROW_W    = DefRowW,
    parameter int unsigned DIM_W    = DefDimW,
    parameter int unsigned TEX_AW   = DefTexAw
) (
    input  logic              en_i,
    input  logic [XG_W-1:0]   sx_i,
    input  logic [ROW_W-1:0]  sy_i,
    input  logic [DIM_W-1:0]  wg_i,
    input  logic [DIM_W-1:0]  h_i,
    input  logic [TEX_AW-1:0] base_i,
    input  logic [XG_W-1:0]   xg_i,
    input  logic [ROW_W-1:0]  row_i,
    output logic              hit_o,
    output logic [TEX_AW-1:0] addr_o
);

    // One extra bit so that sx+wg and sy+h cannot wrap.
    localparam int unsigned CW = DIM_W + 1;

    logic [CW-1:0] xg_w, sx_w, sy_w, wg_w, h_w, posy_w, sx_end, sy_end;
    logic [TEX_AW-1:0] h_a, dx_a, dy_a;

    assign xg_w   = CW'(xg_i);
    assign sx_w   = CW'(sx_i);
    assign sy_w   = CW'(sy_i);
    assign wg_w   = CW'(wg_i);
    assign h_w    = CW'(h_i);
    // Row 0 is the top line; sprite y grows upward from the bottom.
    assign posy_w = CW'(SCREEN_H - 1) - CW'(row_i);
    assign sx_end = sx_w + wg_w;
    assign sy_end = sy_w + h_w;

    assign hit_o = en_i && (wg_w != '0) && (h_w != '0) &&
                   (xg_w >= sx_w) && (xg_w < sx_end) &&
                   (posy_w >= sy_w) && (posy_w < sy_end);

    // Textures are stored column-major, top row of each column first.
    assign h_a    = TEX_AW'(h_i);
    assign dx_a   = TEX_AW'(xg_w - sx_w);
    assign dy_a   = TEX_AW'(sy_end - CW'(1) - posy_w);
    assign addr_o = base_i + h_a * dx_a + dy_a;

endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: composes one 8-pixel texture byte per driver request from
// a table of up to NUM_SPRITES sprites.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   req_valid/req_ready/req_xg/req_row : driver request (ready only when idle)
//   rsp_valid/rsp_ready/rsp_data  : composed byte, held until accepted
//   tex_rd/tex_addr/tex_data      : texture ROM port, data one cycle after tex_rd
//   cfg_we/cfg_idx/cfg_en/cfg_xg/cfg_y/cfg_wg/cfg_h/cfg_base : shadow table write
//   cfg_commit                    : copy shadow table to active table
//   prio_mode                     : 0 = OR all hits, 1 = lowest index wins
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = DefNumSprites,
    parameter int unsigned SCREEN_H    = DefScreenH,
    parameter int unsigned XG_W        = DefXgW,
    parameter int unsigned ROW_W       = DefRowW,
    parameter int unsigned DIM_W       = DefDimW,
    parameter int unsigned TEX_AW      = DefTexAw
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XG_W-1:0]   req_xg,
    input  logic [ROW_W-1:0]  req_row,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_data,
    output logic              tex_rd,
    output logic [TEX_AW-1:0] tex_addr,
    input  logic [7:0]        tex_data,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_idx,
    input  logic              cfg_en,
    input  logic [XG_W-1:0]   cfg_xg,
    input  logic [ROW_W-1:0]  cfg_y,
    input  logic [DIM_W-1:0]  cfg_wg,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [TEX_AW-1:0] cfg_base,
    input  logic              cfg_commit,
    input  logic              prio_mode
);

    localparam int unsigned IdxW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_SPRITES - 1);

    // Shadow and active descriptor tables, one packed array per field.
    logic [NUM_SPRITES-1:0]             sh_en_q, sh_en_d, act_en_q, act_en_d;
    logic [NUM_SPRITES-1:0][XG_W-1:0]   sh_xg_q, sh_xg_d, act_xg_q, act_xg_d;
    logic [NUM_SPRITES-1:0][ROW_W-1:0]  sh_y_q, sh_y_d, act_y_q, act_y_d;
    logic [NUM_SPRITES-1:0][DIM_W-1:0]  sh_wg_q, sh_wg_d, act_wg_q, act_wg_d;
    logic [NUM_SPRITES-1:0][DIM_W-1:0]  sh_h_q, sh_h_d, act_h_q, act_h_d;
    logic [NUM_SPRITES-1:0][TEX_AW-1:0] sh_base_q, sh_base_d, act_base_q, act_base_d;
    logic commit_pend_q, commit_pend_d;
    logic commit_now;
    logic [IdxW-1:0] widx;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              drain_q, drain_d;
    logic              found_q, found_d;
    logic [XG_W-1:0]   xg_q, xg_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              tex_rd_q, tex_rd_d;
    logic [TEX_AW-1:0] tex_addr_q, tex_addr_d;
    logic              rd_pipe_q, rd_pipe_d;
    logic [7:0]        acc_q, acc_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_data_q, rsp_data_d;

    logic              cur_hit;
    logic [TEX_AW-1:0] cur_addr;

    assign widx = cfg_idx[IdxW-1:0];

    // A commit is only applied in IDLE; one seen while busy waits until then.
    assign commit_now = (state_q == StIdle) && (cfg_commit || commit_pend_q);

    always_comb begin
        sh_en_d   = sh_en_q;
        sh_xg_d   = sh_xg_q;
        sh_y_d    = sh_y_q;
        sh_wg_d   = sh_wg_q;
        sh_h_d    = sh_h_q;
        sh_base_d = sh_base_q;
        if (cfg_we && (32'(cfg_idx) < NUM_SPRITES)) begin
            sh_en_d[widx]   = cfg_en;
            sh_xg_d[widx]   = cfg_xg;
            sh_y_d[widx]    = cfg_y;
            sh_wg_d[widx]   = cfg_wg;
            sh_h_d[widx]    = cfg_h;
            sh_base_d[widx] = cfg_base;
        end

        act_en_d   = act_en_q;
        act_xg_d   = act_xg_q;
        act_y_d    = act_y_q;
        act_wg_d   = act_wg_q;
        act_h_d    = act_h_q;
        act_base_d = act_base_q;
        // Copy from the _d view so a same-cycle write is included.
        if (commit_now) begin
            act_en_d   = sh_en_d;
            act_xg_d   = sh_xg_d;
            act_y_d    = sh_y_d;
            act_wg_d   = sh_wg_d;
            act_h_d    = sh_h_d;
            act_base_d = sh_base_d;
        end

        commit_pend_d = commit_pend_q;
        if (commit_now) begin
            commit_pend_d = 1'b0;
        end else if (cfg_commit) begin
            commit_pend_d = 1'b1;
        end
    end

    sprite_hit_addr #(
        .SCREEN_H (SCREEN_H),
        .XG_W     (XG_W),
        .ROW_W    (ROW_W),
        .DIM_W    (DIM_W),
        .TEX_AW   (TEX_AW)
    ) u_hit_addr (
        .en_i   (act_en_q[idx_q]),
        .sx_i   (act_xg_q[idx_q]),
        .sy_i   (act_y_q[idx_q]),
        .wg_i   (act_wg_q[idx_q]),
        .h_i    (act_h_q[idx_q]),
        .base_i (act_base_q[idx_q]),
        .xg_i   (xg_q),
        .row_i  (row_q),
        .hit_o  (cur_hit),
        .addr_o (cur_addr)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        drain_d     = drain_q;
        found_d     = found_q;
        xg_d        = xg_q;
        row_d       = row_q;
        tex_rd_d    = 1'b0;
        tex_addr_d  = tex_addr_q;
        rd_pipe_d   = tex_rd_q;
        // ROM data lands two edges after the fetch decision.
        acc_d       = rd_pipe_q ? (acc_q | tex_data) : acc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    xg_d    = req_xg;
                    row_d   = req_row;
                    acc_d   = '0;
                    found_d = 1'b0;
                    idx_d   = '0;
                    drain_d = 1'b0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (cur_hit && !(prio_mode && found_q)) begin
                    tex_rd_d   = 1'b1;
                    tex_addr_d = cur_addr;
                    found_d    = 1'b1;
                end
                if (idx_q == LastIdx) begin
                    state_d = StDrain;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDrain: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = acc_q;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_en_q       <= '0;
            sh_xg_q       <= '0;
            sh_y_q        <= '0;
            sh_wg_q       <= '0;
            sh_h_q        <= '0;
            sh_base_q     <= '0;
            act_en_q      <= '0;
            act_xg_q      <= '0;
            act_y_q       <= '0;
            act_wg_q      <= '0;
            act_h_q       <= '0;
            act_base_q    <= '0;
            commit_pend_q <= 1'b0;
            idx_q         <= '0;
            drain_q       <= 1'b0;
            found_q       <= 1'b0;
            xg_q          <= '0;
            row_q         <= '0;
            tex_rd_q      <= 1'b0;
            tex_addr_q    <= '0;
            rd_pipe_q     <= 1'b0;
            acc_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
        end else begin
            sh_en_q       <= sh_en_d;
            sh_xg_q       <= sh_xg_d;
            sh_y_q        <= sh_y_d;
            sh_wg_q       <= sh_wg_d;
            sh_h_q        <= sh_h_d;
            sh_base_q     <= sh_base_d;
            act_en_q      <= act_en_d;
            act_xg_q      <= act_xg_d;
            act_y_q       <= act_y_d;
            act_wg_q      <= act_wg_d;
            act_h_q       <= act_h_d;
            act_base_q    <= act_base_d;
            commit_pend_q <= commit_pend_d;
            idx_q         <= idx_d;
            drain_q       <= drain_d;
            found_q       <= found_d;
            xg_q          <= xg_d;
            row_q         <= row_d;
            tex_rd_q      <= tex_rd_d;
            tex_addr_q    <= tex_addr_d;
            rd_pipe_q     <= rd_pipe_d;
            acc_q         <= acc_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign tex_rd    = tex_rd_q;
    assign tex_addr  = tex_addr_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a reference model of the
// descriptor tables, hit rules and texture addressing.
module tb_sprite_compositor;
    import sprite_pkg::*;

    localparam int N  = 4;
    localparam int SH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, tex_rd;
    logic [4:0]  req_xg, cfg_xg;
    logic [5:0]  req_row, cfg_y;
    logic [7:0]  rsp_data, cfg_wg, cfg_h;
    logic [7:0]  tex_data = 8'h00;
    logic [15:0] tex_addr, cfg_base;
    logic        cfg_we, cfg_en, cfg_commit, prio_mode;
    logic [3:0]  cfg_idx;

    sprite_compositor #(
        .NUM_SPRITES (N),
        .SCREEN_H    (SH),
        .XG_W        (5),
        .ROW_W       (6),
        .DIM_W       (8),
        .TEX_AW      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_xg     (req_xg),
        .req_row    (req_row),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .tex_rd     (tex_rd),
        .tex_addr   (tex_addr),
        .tex_data   (tex_data),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_en     (cfg_en),
        .cfg_xg     (cfg_xg),
        .cfg_y      (cfg_y),
        .cfg_wg     (cfg_wg),
        .cfg_h      (cfg_h),
        .cfg_base   (cfg_base),
        .cfg_commit (cfg_commit),
        .prio_mode  (prio_mode)
    );

    always #5 clk = ~clk;

    // Texture ROM with one cycle of read latency.
    logic [7:0] rom [256];
    always @(posedge clk) if (tex_rd) tex_data <= rom[tex_addr[7:0]];

    int vecs = 0;
    int errs = 0;

    desc_t sh_m [N];
    desc_t act_m [N];
    int    exp_q [$];
    logic [7:0] exp_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected fetch addresses and composed byte from the active table.
    task automatic model_run(input int xg, input int row);
        int posy, sx, sy, wg, h, a;
        bit found;
        exp_q.delete();
        exp_data = 8'h00;
        found = 0;
        posy = SH - 1 - row;
        for (int i = 0; i < N; i++) begin
            sx = int'(act_m[i].xg);
            sy = int'(act_m[i].y);
            wg = int'(act_m[i].wg);
            h  = int'(act_m[i].h);
            if (act_m[i].en && xg >= sx && xg < sx + wg && posy >= sy && posy < sy + h &&
                !(prio_mode && found)) begin
                a = (int'(act_m[i].base) + h * (xg - sx) + (sy + h - 1 - posy)) % 65536;
                exp_q.push_back(a);
                exp_data = exp_data | rom[a % 256];
                found = 1;
            end
        end
    endtask

    task automatic cfg_write(input int idx, input bit en, input int xg, input int y,
                             input int wg, input int h, input int base, input bit commit);
        cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_en = en; cfg_xg = 5'(xg); cfg_y = 6'(y);
        cfg_wg = 8'(wg); cfg_h = 8'(h); cfg_base = 16'(base); cfg_commit = commit;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_commit = 1'b0;
        if (idx < N) begin
            sh_m[idx].en   = en;
            sh_m[idx].xg   = DefXgW'(xg);
            sh_m[idx].y    = DefRowW'(y);
            sh_m[idx].wg   = DefDimW'(wg);
            sh_m[idx].h    = DefDimW'(h);
            sh_m[idx].base = DefTexAw'(base);
        end
        if (commit) act_m = sh_m;
    endtask

    // One request: model check against literals, latency, data, fetches,
    // optional backpressure and optional commit pulse while busy.
    task automatic run_req(input string tag, input int xg, input int row, input int stall,
                           input int commit_at, input int lit_data, input int lit_n,
                           input int lit_a0);
        int got [$];
        int waitc;
        bit early;
        model_run(xg, row);
        chk({tag, " model data"}, 32'(exp_data), 32'(lit_data));
        chk({tag, " model nfetch"}, exp_q.size(), lit_n);
        if (lit_n > 0) chk({tag, " model addr0"}, exp_q[0], lit_a0);

        req_xg = 5'(xg); req_row = 6'(row); req_valid = 1'b1;
        rsp_ready = (stall == 0);
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(posedge clk); #1; waitc++;
        end
        chk({tag, " req_ready"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        early = 0;
        for (int c = 1; c <= N + 3; c++) begin
            if (c == commit_at) cfg_commit = 1'b1;
            @(posedge clk); #1;
            cfg_commit = 1'b0;
            if (tex_rd) got.push_back(int'(tex_addr));
            if (c < N + 3 && rsp_valid) early = 1;
        end
        chk({tag, " early rsp_valid"}, early, 0);
        chk({tag, " rsp_valid at N+3"}, rsp_valid, 1);
        chk({tag, " rsp_data"}, rsp_data, exp_data);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            if (tex_rd) got.push_back(int'(tex_addr));
            chk({tag, " stall rsp_valid"}, rsp_valid, 1);
            chk({tag, " stall rsp_data"}, rsp_data, exp_data);
            chk({tag, " stall req_ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, " rsp_valid after accept"}, rsp_valid, 0);
        chk({tag, " req_ready after accept"}, req_ready, 1);
        chk({tag, " nfetch"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk({tag, " fetch addr"}, got[i], exp_q[i]);
        if (commit_at > 0) act_m = sh_m;
    endtask

    initial begin
        int waitc;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[32] = 8'hA5; rom[77] = 8'h0F; rom[55] = 8'h3C; rom[23] = 8'h81;
        for (int i = 0; i < N; i++) begin
            sh_m[i] = '0; act_m[i] = '0;
        end
        rst = 1'b1; req_valid = 1'b0; req_xg = '0; req_row = '0; rsp_ready = 1'b1;
        cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_xg = '0; cfg_y = '0;
        cfg_wg = '0; cfg_h = '0; cfg_base = '0; cfg_commit = 1'b0; prio_mode = 1'b0;
        #12;
        chk("reset req_ready", req_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_data", rsp_data, 0);
        chk("reset tex_rd", tex_rd, 0);
        chk("reset tex_addr", tex_addr, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        cfg_write(0, 1, 1, 0, 3, 23, 0, 1);
        run_req("single", 2, 50, 0, 0, 'hA5, 1, 32);
        chk("tex_addr holds", tex_addr, 32);
        run_req("miss", 5, 50, 0, 0, 'h00, 0, 0);
        run_req("right edge", 3, 50, 0, 0, 'h3C, 1, 55);
        run_req("past right", 4, 50, 0, 0, 'h00, 0, 0);
        run_req("top row", 2, 41, 0, 0, 'h81, 1, 23);
        run_req("above top", 2, 40, 0, 0, 'h00, 0, 0);

        cfg_write(4, 0, 0, 0, 0, 0, 0, 1);
        run_req("idx oob ignored", 2, 50, 0, 0, 'hA5, 1, 32);

        cfg_write(1, 1, 2, 0, 2, 22, 69, 1);
        prio_mode = 1'b0;
        run_req("overlap or", 2, 50, 0, 0, 'hAF, 2, 32);
        prio_mode = 1'b1;
        run_req("overlap prio", 2, 50, 0, 0, 'hA5, 1, 32);
        prio_mode = 1'b0;
        run_req("backpressure", 2, 50, 5, 0, 'hAF, 2, 32);

        cfg_write(2, 1, 2, 0, 0, 10, 200, 0);
        cfg_write(3, 1, 2, 0, 1, 0, 210, 1);
        run_req("zero dims", 2, 50, 0, 0, 'hAF, 2, 32);

        // Shadow edits without a commit must not affect the active table.
        cfg_write(0, 1, 10, 0, 3, 23, 0, 0);
        cfg_write(1, 0, 2, 0, 2, 22, 69, 0);
        cfg_write(2, 0, 0, 0, 0, 0, 0, 0);
        cfg_write(3, 0, 0, 0, 0, 0, 0, 0);
        prio_mode = 1'b1;
        run_req("shadow only", 2, 50, 0, 0, 'hA5, 1, 32);
        run_req("commit busy", 2, 50, 0, 2, 'hA5, 1, 32);
        run_req("after commit", 2, 50, 0, 0, 'h00, 0, 0);
        cfg_write(0, 1, 1, 0, 3, 23, 0, 1);
        run_req("write+commit", 2, 50, 0, 0, 'hA5, 1, 32);

        // Reset in the middle of a scan.
        prio_mode = 1'b0;
        cfg_write(1, 1, 2, 0, 2, 22, 69, 1);
        req_xg = 5'd2; req_row = 6'd50; req_valid = 1'b1;
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(posedge clk); #1; waitc++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midreset rsp_valid", rsp_valid, 0);
        chk("midreset tex_rd", tex_rd, 0);
        chk("midreset req_ready", req_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("postreset tex_addr", tex_addr, 0);
        for (int i = 0; i < N; i++) begin
            sh_m[i] = '0; act_m[i] = '0;
        end
        @(posedge clk); #1;
        chk("postreset rsp_valid", rsp_valid, 0);
        run_req("enables cleared", 2, 50, 0, 0, 'h00, 0, 0);
        cfg_write(0, 1, 1, 0, 3, 23, 0, 1);
        run_req("after reset", 2, 50, 0, 0, 'hA5, 1, 32);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor to the single-rex/single-obstacle pixel decider.
- Serves the display driver with 8-pixel texture bytes at (column group, row) for up to NUM_SPRITES sprites held in a descriptor table.
- Runs a sequential scan FSM over the sprites and fetches texture bytes with a 1-cycle-latency ROM read. Overlaps are merged by OR or by priority.
- Sits between the display driver, the texture ROM and the game logic, which writes the sprite descriptors.

Parameters:
- NUM_SPRITES, 4: descriptor table depth (1..16).
- SCREEN_H, 64: screen rows; posy = SCREEN_H-1-req_row.
- XG_W, 5: width of column-group index (8-pixel units).
- ROW_W, 6: row index width.
- DIM_W, 8: sprite width (groups) / height (rows) field width.
- TEX_AW, 16: texture ROM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  driver pixel-byte request.
- req_ready  out  1  high only in IDLE.
- req_xg  in  XG_W  column group.
- req_row  in  ROW_W  row, 0 = top line.
- rsp_valid  out  1  composed byte available.
- rsp_ready  in  1  driver accepts rsp_data.
- rsp_data  out  8  composed byte.
- tex_rd  out  1  texture read strobe (registered).
- tex_addr  out  TEX_AW  texture address (registered).
- tex_data  in  8  valid the cycle after tex_rd.
- cfg_we  in  1  write shadow descriptor.
- cfg_idx  in  4  sprite index.
- cfg_en  in  1  sprite enable.
- cfg_xg  in  XG_W  left column group.
- cfg_y  in  ROW_W  bottom y.
- cfg_wg  in  DIM_W  width in groups.
- cfg_h  in  DIM_W  height in rows.
- cfg_base  in  TEX_AW  texture base.
- cfg_commit  in  1  copy all shadow descriptors to the active table.
- prio_mode  in  1  0 = OR merge, 1 = lowest index wins.

Behaviour:
- Reset: FSM to IDLE. req_ready=1; rsp_valid=0, rsp_data=0, tex_rd=0, tex_addr=0. Shadow and active enables cleared; other descriptor fields are 0.
- Reset mid-operation: abort immediately; no response is produced.
- Descriptor writes:
  - cfg_we writes the shadow entry cfg_idx; cfg_idx >= NUM_SPRITES is ignored.
  - cfg_commit copies shadow to active in one cycle, but only while in IDLE. A commit pulse arriving while busy is latched as pending and applied on return to IDLE, before the next request is accepted.
  - cfg_we and cfg_commit in the same cycle: the commit copies the table including the new write.
- Hit test for sprite i against posy=SCREEN_H-1-req_row:
  - Condition: en && xg>=sx && xg<sx+wg && posy>=sy && posy<sy+h.
  - Comparisons are unsigned, widened to DIM_W+1 bits, so sx+wg and sy+h never wrap.
  - wg=0 or h=0 means never hit.
- Texture address: base + h*(xg-sx) + (sy+h-1-posy), truncated to TEX_AW.
- FSM IDLE:
  - req_valid&&req_ready latches xg and row, clears the accumulator and the found flag, sets idx=0, and moves to SCAN.
- FSM SCAN: one sprite per cycle.
  - On a hit (and, in prio_mode, !found), register tex_rd=1 with tex_addr and set found.
  - A tex_data that returns is ORed into the accumulator (prio_mode: at most one fetch occurs, so OR equals replacement).
  - After idx=NUM_SPRITES-1, go to DRAIN.
- FSM DRAIN: two cycles to retire the last read; then go to RESP.
- FSM RESP:
  - rsp_valid=1 and rsp_data=accumulator, held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, return to IDLE.
- Latency: rsp_valid rises exactly NUM_SPRITES+3 clocks after the acceptance edge, regardless of hits.
- No hits: rsp_data=0 and tex_rd never pulses.
- tex_rd is a single-cycle pulse per fetch; tex_addr holds its value between fetches.
- prio_mode and the descriptors are sampled continuously. Changing them while busy is a usage error, and the result is undefined but must not hang the FSM.

Decomposition:
- Package sprite_pkg: state encoding (IDLE, SCAN, DRAIN, RESP), descriptor struct/field widths, default parameters.
- One sub-module, sprite_hit_addr: combinational hit test plus texture-address computation for one descriptor, instantiated once on the scan mux output.

Test Plan:
- Single hit, shared setup: sprite0 {en, xg=1, y=0, wg=3, h=23, base=0}; request xg=2, row=50 (posy=13).
  - Expect one tex_rd with tex_addr=32.
  - With tex_data=0xA5, expect rsp_data=0xA5 at exactly cycle N+3.
- Miss: same setup, request xg=5, row=50 -> no tex_rd, rsp_data=0x00.
- Overlap: add sprite1 {en, xg=2, y=0, wg=2, h=22, base=69}; second fetch tex_addr=77 returns 0x0F.
  - prio_mode=0 -> 0xAF.
  - prio_mode=1 -> 0xA5, only one tex_rd.
- Shadow/commit:
  - Rewrite sprite0 xg=10 without commit -> still hits at xg=2.
  - cfg_commit while busy -> applied after the response; the next request at xg=2 misses.
- Backpressure/reset:
  - Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0.
  - Assert rst during SCAN -> next cycle rsp_valid=0, tex_rd=0, req_ready=1, all enables cleared.
